datapoint_stream_memory: RTL and testbench

//  Parametrised successor of the single-port datapoint memory.

---
 rtl/datapoint_stream_memory.sv | 173 +++++++++++++++++
 tb/tb_datapoint_stream_memory.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapoint_stream_memory.sv
// datapoint_stream_memory
// DEPTH x DATA_W datapoint store with one write port and a burst-read
// engine. The engine streams LEN consecutive words (wrapping at DEPTH)
// through a valid/ready port. A one-cycle synchronous read feeds a
// 2-entry skid FIFO, and the FIFO head drives the stream outputs.
module datapoint_stream_memory #(
    parameter int    DATA_W    = 18,
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wrEna,
    input  logic [ADDR_W-1:0] io_wrAddr,
    input  logic [DATA_W-1:0] io_wrData,
    input  logic              io_start,
    input  logic [ADDR_W-1:0] io_startAddr,
    input  logic [ADDR_W:0]   io_len,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DATA_W-1:0] io_out_bits,
    output logic              io_out_last
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic [LEN_W-1:0]    len_clamped;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Read stage: one word is in flight between the array and the FIFO.
    logic                rd_valid_q;
    logic                rd_last_q;
    logic [DATA_W-1:0]   rd_data_q;

    // Skid FIFO: two entries, one-bit pointers, occupancy 0..2.
    logic [DATA_W-1:0]   fifo_data_q [2];
    logic                fifo_last_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;

    logic                pop;
    logic [1:0]          occ_after;
    logic                issue;

    // Handshake, occupancy and read-issue decision.
    always_comb begin
        pop         = (count_q != 2'd0) && io_out_ready;
        // Words held after this edge, counting the one arriving from the read stage.
        occ_after   = count_q + {1'b0, rd_valid_q} - {1'b0, pop};
        // A new read only when its word is guaranteed a free FIFO slot.
        issue       = (state_q == S_READ) && (occ_after < 2'd2);
        len_clamped = (io_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : io_len;
    end

    // Burst FSM next-state and address/beat counters.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        unique case (state_q)
            S_IDLE: begin
                if (io_start && (io_len != '0)) begin
                    addr_d   = io_startAddr;
                    remain_d = len_clamped;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!rd_valid_q && (occ_after == 2'd0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and burst counters, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    // Write port; accepted in every state and every cycle.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset, so its contents survive a reset and it maps onto RAM.
        if (io_wrEna) begin
            mem_q[io_wrAddr] <= io_wrData;
        end
    end

    // Synchronous read into the read-stage register.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignment makes a read on the same edge as a write to that word return the old data.
        if (issue) begin
            rd_data_q <= mem_q[addr_q];
            rd_last_q <= (remain_q == LEN_W'(1));
        end
    end

    // Skid FIFO storage; entries are only read while they are counted valid.
    always_ff @(posedge clock) begin
        if (rd_valid_q) begin
            fifo_data_q[wr_ptr_q] <= rd_data_q;
            fifo_last_q[wr_ptr_q] <= rd_last_q;
        end
    end

    // Read-stage valid and FIFO pointers/occupancy; reset flushes both.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            rd_valid_q <= issue;
            if (rd_valid_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= occ_after;
        end
    end

    // Stream and status outputs; bits read as zero whenever nothing is offered.
    always_comb begin
        io_busy      = (state_q != S_IDLE);
        io_done      = (state_q == S_DONE);
        io_out_valid = (count_q != 2'd0);
        io_out_bits  = io_out_valid ? fifo_data_q[rd_ptr_q] : '0;
        io_out_last  = io_out_valid && fifo_last_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_datapoint_stream_memory.sv
// Bench for datapoint_stream_memory: table of bursts over a known memory
// image, hand sequences for collision/reset/ignored-start corners, then
// random writes and bursts checked against an array model of the memory.
`timescale 1ns/1ps
module tb_datapoint_stream_memory;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              io_wrEna = 1'b0;
    logic [ADDR_W-1:0] io_wrAddr = '0;
    logic [DATA_W-1:0] io_wrData = '0;
    logic              io_start = 1'b0;
    logic [ADDR_W-1:0] io_startAddr = '0;
    logic [ADDR_W:0]   io_len = '0;
    logic              io_busy;
    logic              io_done;
    logic              io_out_valid;
    logic              io_out_ready = 1'b0;
    logic [DATA_W-1:0] io_out_bits;
    logic              io_out_last;

    datapoint_stream_memory #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_wrEna    (io_wrEna),
        .io_wrAddr   (io_wrAddr),
        .io_wrData   (io_wrData),
        .io_start    (io_start),
        .io_startAddr(io_startAddr),
        .io_len      (io_len),
        .io_busy     (io_busy),
        .io_done     (io_done),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_out_bits (io_out_bits),
        .io_out_last (io_out_last)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];

    typedef struct {
        int addr;
        int len;
        int mode;
        bit timing;
        int exp_beats;
        int exp_first;
        int exp_last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input int a, input int d);
        io_wrEna  = 1'b1;
        io_wrAddr = ADDR_W'(a);
        io_wrData = DATA_W'(d);
        tick();
        io_wrEna  = 1'b0;
        model_mem[a] = DATA_W'(d);
    endtask

    // Consumer ready pattern: 0 always, 1 fixed 1,0,0,1,0,1 cycle, 2 mostly ready, 3 coin flip.
    function automatic bit rdy(input int mode, input int c);
        bit [5:0] pat;
        pat = 6'b101001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[c % 6];
            2:       return ($urandom % 4) != 0;
            default: return ($urandom % 2) != 0;
        endcase
    endfunction

    // Runs one burst. Cycle index c counts edges after the accept edge T.
    task automatic run_burst(input string name, input int addr, input int len, input int mode,
                             input bit chk_timing, input int wr_cycle, input int wr_a, input int wr_d,
                             input int abort_beats, input bit poke_start,
                             output int first_word, output int last_word, output int beats);
        int eff;
        logic [DATA_W-1:0] exp_q[$];
        int nb, done_cnt, first_c, last_c, done_c, end_c, bad;
        bit pv, pr, pl, r;
        logic [DATA_W-1:0] pb;
        eff = (len > DEPTH) ? DEPTH : len;
        nb = 0; done_cnt = 0; first_c = -1; last_c = -1; done_c = -1; end_c = -1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pb = '0;
        first_word = -1; last_word = -1;
        for (int k = 0; k < eff; k++) exp_q.push_back(model_mem[(addr + k) % DEPTH]);
        io_startAddr = ADDR_W'(addr);
        io_len       = (ADDR_W + 1)'(len);
        io_start     = 1'b1;
        io_out_ready = 1'b1;
        tick();
        io_start = 1'b0;
        for (int c = 0; c < eff * 8 + 32; c++) begin
            if (!io_busy) begin
                end_c = c;
                break;
            end
            r = rdy(mode, c);
            io_out_ready = r;
            io_wrEna  = (c == wr_cycle);
            io_wrAddr = ADDR_W'(wr_a);
            io_wrData = DATA_W'(wr_d);
            if (poke_start && c >= 1) begin
                io_start     = 1'b1;
                io_startAddr = ADDR_W'(900);
                io_len       = (ADDR_W + 1)'(5);
            end
            if (pv && !pr) begin
                check($sformatf("%s hold valid c%0d", name, c), 32'(io_out_valid), 32'd1);
                check($sformatf("%s hold bits c%0d", name, c), 32'(io_out_bits), 32'(pb));
                check($sformatf("%s hold last c%0d", name, c), 32'(io_out_last), 32'(pl));
            end
            if (io_out_valid && r) begin
                if (nb < eff) begin
                    check($sformatf("%s beat%0d bits", name, nb), 32'(io_out_bits), 32'(exp_q[nb]));
                    check($sformatf("%s beat%0d last", name, nb), 32'(io_out_last), 32'(nb == eff - 1));
                end else begin
                    check($sformatf("%s extra beat", name), 32'(nb + 1), 32'(eff));
                end
                if (nb == 0) begin
                    first_c    = c;
                    first_word = int'(io_out_bits);
                end
                last_word = int'(io_out_bits);
                if (io_out_last) last_c = c;
                nb++;
                if (abort_beats != 0 && nb == abort_beats) begin
                    io_wrEna = 1'b0;
                    tick();
                    reset = 1'b0;
                    tick();
                    reset = 1'b1;
                    io_start = 1'b0;
                    check($sformatf("%s abort valid", name), 32'(io_out_valid), 32'd0);
                    check($sformatf("%s abort busy", name), 32'(io_busy), 32'd0);
                    check($sformatf("%s abort done", name), 32'(io_done), 32'd0);
                    check($sformatf("%s abort bits", name), 32'(io_out_bits), 32'd0);
                    bad = 0;
                    for (int k = 0; k < 6; k++) begin
                        tick();
                        if (io_done || io_out_valid || io_busy) bad++;
                    end
                    check($sformatf("%s quiet after abort", name), 32'(bad), 32'd0);
                    beats = nb;
                    return;
                end
            end
            if (io_done) begin
                done_cnt++;
                done_c = c;
            end
            pv = io_out_valid; pr = r; pb = io_out_bits; pl = io_out_last;
            tick();
        end
        io_start = 1'b0;
        io_wrEna = 1'b0;
        beats = nb;
        if (wr_cycle >= 0) model_mem[wr_a] = DATA_W'(wr_d);
        check($sformatf("%s finished in budget", name), 32'(end_c >= 0), 32'd1);
        check($sformatf("%s beat count", name), 32'(nb), 32'(eff));
        check($sformatf("%s done pulses", name), 32'(done_cnt), 32'd1);
        if (chk_timing) begin
            check($sformatf("%s first valid cycle", name), 32'(first_c), 32'd2);
            check($sformatf("%s last beat cycle", name), 32'(last_c), 32'(1 + eff));
            check($sformatf("%s done cycle", name), 32'(done_c), 32'(2 + eff));
            check($sformatf("%s busy low cycle", name), 32'(end_c), 32'(3 + eff));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        int fw, lw, nb, bad;

        vecs[0] = '{addr: 5,    len: 4,    mode: 0, timing: 1, exp_beats: 4,    exp_first: 5,    exp_last: 8};
        vecs[1] = '{addr: 1022, len: 4,    mode: 0, timing: 1, exp_beats: 4,    exp_first: 1022, exp_last: 1};
        vecs[2] = '{addr: 100,  len: 6,    mode: 1, timing: 0, exp_beats: 6,    exp_first: 100,  exp_last: 105};
        vecs[3] = '{addr: 0,    len: 1,    mode: 0, timing: 1, exp_beats: 1,    exp_first: 0,    exp_last: 0};
        vecs[4] = '{addr: 1000, len: 1024, mode: 0, timing: 1, exp_beats: 1024, exp_first: 1000, exp_last: 999};
        vecs[5] = '{addr: 3,    len: 2000, mode: 0, timing: 1, exp_beats: 1024, exp_first: 3,    exp_last: 2};
        vecs[6] = '{addr: 1023, len: 2,    mode: 1, timing: 0, exp_beats: 2,    exp_first: 1023, exp_last: 0};
        vecs[7] = '{addr: 512,  len: 17,   mode: 2, timing: 0, exp_beats: 17,   exp_first: 512,  exp_last: 528};
        vecs[8] = '{addr: 40,   len: 9,    mode: 3, timing: 0, exp_beats: 9,    exp_first: 40,   exp_last: 48};

        // Reset state.
        reset = 1'b0;
        repeat (3) tick();
        check("reset busy", 32'(io_busy), 32'd0);
        check("reset done", 32'(io_done), 32'd0);
        check("reset valid", 32'(io_out_valid), 32'd0);
        check("reset last", 32'(io_out_last), 32'd0);
        check("reset bits", 32'(io_out_bits), 32'd0);
        reset = 1'b1;
        tick();

        // Memory image word[i] = i.
        for (int i = 0; i < DEPTH; i++) write_word(i, i);

        // Table of bursts over the known image.
        for (int v = 0; v < 9; v++) begin
            run_burst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].mode,
                      vecs[v].timing, -1, 0, 0, 0, 1'b0, fw, lw, nb);
            check($sformatf("vec%0d beats", v), 32'(nb), 32'(vecs[v].exp_beats));
            check($sformatf("vec%0d first word", v), 32'(fw), 32'(vecs[v].exp_first));
            check($sformatf("vec%0d last word", v), 32'(lw), 32'(vecs[v].exp_last));
            tick();
        end

        // Write to word 7 on the same edge the burst reads it: old value streams.
        run_burst("collide", 5, 4, 0, 1'b1, 2, 7, 'h3FFFF, 0, 1'b0, fw, lw, nb);
        check("collide last word", 32'(lw), 32'd8);
        tick();
        run_burst("collide rerun", 7, 1, 0, 1'b1, -1, 0, 0, 0, 1'b0, fw, lw, nb);
        check("collide rerun word", 32'(fw), 32'h3FFFF);
        tick();

        // Reset after beat 2 of 8, then a fresh burst.
        run_burst("abort", 200, 8, 0, 1'b0, -1, 0, 0, 2, 1'b0, fw, lw, nb);
        check("abort beats before reset", 32'(nb), 32'd2);
        run_burst("after abort", 300, 5, 0, 1'b1, -1, 0, 0, 0, 1'b0, fw, lw, nb);
        check("after abort first word", 32'(fw), 32'd300);
        tick();

        // len=0 request is ignored.
        io_start     = 1'b1;
        io_startAddr = ADDR_W'(10);
        io_len       = '0;
        io_out_ready = 1'b1;
        tick();
        io_start = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (io_busy || io_out_valid || io_done) bad++;
            tick();
        end
        check("len0 ignored", 32'(bad), 32'd0);

        // start held high throughout a burst is ignored until idle.
        run_burst("start while busy", 50, 3, 0, 1'b1, -1, 0, 0, 0, 1'b1, fw, lw, nb);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (io_busy || io_out_valid || io_done) bad++;
            tick();
        end
        check("start while busy ignored", 32'(bad), 32'd0);

        // Random writes and bursts against the array model.
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) write_word($urandom_range(0, DEPTH - 1), $urandom_range(0, 'h3FFFF));
            run_burst($sformatf("rand%0d", it), $urandom_range(0, DEPTH - 1), $urandom_range(1, 48),
                      2 + (it % 2), 1'b0, -1, 0, 0, 0, 1'b0, fw, lw, nb);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
